// File: rtl/aes_128_sched.sv
// Round-robin scheduler sharing one fixed-latency, fully pipelined AES-128 core between requesters A and B.
// Credits cover blocks in flight plus buffered results, so the non-stallable core can never overflow the FIFO.
module aes_128_sched #(
    parameter int LAT   = 21,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [127:0] a_state,
    input  logic [127:0] a_key,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [127:0] b_state,
    input  logic [127:0] b_key,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_src,
    output logic         busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]  cnt;
    logic [CW-1:0]  occ;
    logic           last;
    logic           credit_ok;
    logic           grant_a;
    logic           grant_b;
    logic           issue;
    logic           push;
    logic           pop;
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_src;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [128:0]   mem [DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees its credit only from the next cycle on, because credit_ok uses the registered count.
    assign credit_ok = (cnt < CW'(DEPTH));

    // Handshake: a block transfers on a cycle where valid and ready are both high. Ready is the grant
    // itself and may depend on valid; a requester must not make valid depend on ready.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && credit_ok) begin
            if (a_valid && b_valid) begin
                grant_a = last;
                grant_b = ~last;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign issue      = grant_a | grant_b;
    assign core_state = grant_a ? a_state : (grant_b ? b_state : '0);
    assign core_key   = grant_a ? a_key : (grant_b ? b_key : '0);

    assign push      = tag_v[LAT-1];
    assign res_valid = (occ != '0);
    assign pop       = res_valid & res_ready;
    assign res_data  = res_valid ? mem[rd_ptr][127:0] : '0;
    assign res_src   = res_valid & mem[rd_ptr][128];
    assign busy      = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            occ    <= '0;
            last   <= 1'b1;
            tag_v  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (issue && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !issue) begin
                cnt <= cnt - 1'b1;
            end
            if (issue) begin
                last <= grant_b;
            end
            tag_v[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    // Source tags and FIFO storage need no reset: only the valid bits and pointers give them meaning.
    always_ff @(posedge clk) begin
        tag_src[0] <= grant_b;
        for (int i = 1; i < LAT; i++) begin
            tag_src[i] <= tag_src[i-1];
        end
        if (push && !rst) begin
            mem[wr_ptr] <= {tag_src[LAT-1], core_out};
        end
    end
endmodule

// File: tb/tb_aes_128_sched.sv
// Bench for aes_128_sched: two instances (DEPTH 32 and DEPTH 4) each backed by a behavioural AES-128 core.
// A scoreboard of expected {src, ciphertext} follows issue order; scenario tasks check timing inline.
module tb_aes_128_sched;
    localparam int LAT = 21;
    localparam int DL  = 32;
    localparam int DS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         a_valid = 1'b0;
    logic         b_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic [127:0] a_state = '0;
    logic [127:0] a_key = '0;
    logic [127:0] b_state = '0;
    logic [127:0] b_key = '0;

    int checks = 0;
    int errors = 0;
    int pops = 0;

    logic [128:0] exp_q [$];
    logic [1:0]   last_ref = 2'b11;
    logic [7:0]   sbox [256];

    logic         l_a_ready, l_b_ready, l_res_valid, l_res_src, l_busy;
    logic [127:0] l_core_state, l_core_key, l_core_out, l_res_data;
    logic         s_a_ready, s_b_ready, s_res_valid, s_res_src, s_busy;
    logic [127:0] s_core_state, s_core_key, s_core_out, s_res_data;

    aes_128_sched #(.LAT(LAT), .DEPTH(DL)) l_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid & ~sel), .a_ready(l_a_ready), .a_state(a_state), .a_key(a_key),
        .b_valid(b_valid & ~sel), .b_ready(l_b_ready), .b_state(b_state), .b_key(b_key),
        .core_state(l_core_state), .core_key(l_core_key), .core_out(l_core_out),
        .res_valid(l_res_valid), .res_ready(res_ready & ~sel), .res_data(l_res_data),
        .res_src(l_res_src), .busy(l_busy)
    );

    aes_128_sched #(.LAT(LAT), .DEPTH(DS)) s_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid & sel), .a_ready(s_a_ready), .a_state(a_state), .a_key(a_key),
        .b_valid(b_valid & sel), .b_ready(s_b_ready), .b_state(b_state), .b_key(b_key),
        .core_state(s_core_state), .core_key(s_core_key), .core_out(s_core_out),
        .res_valid(s_res_valid), .res_ready(res_ready & sel), .res_data(s_res_data),
        .res_src(s_res_src), .busy(s_busy)
    );

    logic         m_a_ready, m_b_ready, m_res_valid, m_res_src, m_busy;
    logic [127:0] m_core_state, m_core_key, m_res_data;
    assign m_a_ready    = sel ? s_a_ready : l_a_ready;
    assign m_b_ready    = sel ? s_b_ready : l_b_ready;
    assign m_res_valid  = sel ? s_res_valid : l_res_valid;
    assign m_res_src    = sel ? s_res_src : l_res_src;
    assign m_res_data   = sel ? s_res_data : l_res_data;
    assign m_busy       = sel ? s_busy : l_busy;
    assign m_core_state = sel ? s_core_state : l_core_state;
    assign m_core_key   = sel ? s_core_key : l_core_key;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xx;
            xx = xtime(xx);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    initial begin
        logic [7:0] inv;
        logic [7:0] x;
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            end
            x = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                x = {x[6:0], x[7]};
                s = s ^ x;
            end
            sbox[i] = s ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   b [16];
        logic [7:0]   sr [16];
        logic [127:0] s;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
            for (int i = 0; i < 16; i++) sr[i] = b[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = sr[4*c];
                    a1 = sr[4*c+1];
                    a2 = sr[4*c+2];
                    a3 = sr[4*c+3];
                    sr[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    sr[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    sr[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    sr[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sr[i];
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Behavioural cores: LAT-deep delay lines of the ciphertext, no reset.
    logic [127:0] l_pipe [LAT];
    logic [127:0] s_pipe [LAT];
    always @(posedge clk) begin
        l_pipe[0] <= aes_enc(l_core_key, l_core_state);
        s_pipe[0] <= aes_enc(s_core_key, s_core_state);
        for (int i = 1; i < LAT; i++) begin
            l_pipe[i] <= l_pipe[i-1];
            s_pipe[i] <= s_pipe[i-1];
        end
    end
    assign l_core_out = l_pipe[LAT-1];
    assign s_core_out = s_pipe[LAT-1];

    task automatic monitor();
        forever begin
            int           depth_ref;
            logic         exp_ga;
            logic         exp_gb;
            logic [127:0] exp_cs;
            logic [127:0] exp_ck;
            logic [128:0] head;
            @(negedge clk);
            checks += 2;
            if (l_dut.push && int'(l_dut.occ) == DL) begin
                errors++;
                $display("FAIL push_at_full_32: push with occupancy %0d, required below %0d", l_dut.occ, DL);
            end
            if (s_dut.push && int'(s_dut.occ) == DS) begin
                errors++;
                $display("FAIL push_at_full_4: push with occupancy %0d, required below %0d", s_dut.occ, DS);
            end
            if (rst) begin
                exp_q.delete();
                last_ref = 2'b11;
                checks++;
                if ({m_a_ready, m_b_ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL ready_in_reset: got %b%b want 00", m_a_ready, m_b_ready);
                end
            end else begin
                depth_ref = sel ? DS : DL;
                exp_ga = 1'b0;
                exp_gb = 1'b0;
                if (exp_q.size() < depth_ref) begin
                    if (a_valid && b_valid) begin
                        exp_ga = last_ref[sel];
                        exp_gb = ~last_ref[sel];
                    end else begin
                        exp_ga = a_valid;
                        exp_gb = b_valid;
                    end
                end
                exp_cs = exp_ga ? a_state : (exp_gb ? b_state : '0);
                exp_ck = exp_ga ? a_key : (exp_gb ? b_key : '0);
                checks += 4;
                if ({m_a_ready, m_b_ready} !== {exp_ga, exp_gb}) begin
                    errors++;
                    $display("FAIL grant: got a=%b b=%b want a=%b b=%b (outstanding %0d)",
                             m_a_ready, m_b_ready, exp_ga, exp_gb, exp_q.size());
                end
                if (m_core_state !== exp_cs || m_core_key !== exp_ck) begin
                    errors++;
                    $display("FAIL core_drive: got %h/%h want %h/%h", m_core_state, m_core_key, exp_cs, exp_ck);
                end
                if (m_busy !== (exp_q.size() != 0)) begin
                    errors++;
                    $display("FAIL busy: got %b want %b", m_busy, exp_q.size() != 0);
                end
                if (exp_q.size() == 0 && m_res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL res_valid_idle: got %b want 0", m_res_valid);
                end
                if (m_res_valid && res_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_result: got %b%h want none", m_res_src, m_res_data);
                    end else begin
                        head = exp_q.pop_front();
                        pops++;
                        if ({m_res_src, m_res_data} !== head) begin
                            errors++;
                            $display("FAIL result: got src=%b data=%h want src=%b data=%h",
                                     m_res_src, m_res_data, head[128], head[127:0]);
                        end
                    end
                end
                if (m_a_ready && a_valid) begin
                    exp_q.push_back({1'b0, aes_enc(a_key, a_state)});
                    last_ref[sel] = 1'b0;
                end
                if (m_b_ready && b_valid) begin
                    exp_q.push_back({1'b1, aes_enc(b_key, b_state)});
                    last_ref[sel] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        res_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_state = rand128();
        a_key = rand128();
        b_state = rand128();
        b_key = rand128();
        res_ready = 1'b1;
        repeat (3) step();
        #1;
        checks += 4;
        if ({l_a_ready, l_b_ready, s_a_ready, s_b_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b%b%b%b want 0000", l_a_ready, l_b_ready, s_a_ready, s_b_ready);
        end
        if ({l_res_valid, l_busy, s_res_valid, s_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b%b%b%b want 0000", l_res_valid, l_busy, s_res_valid, s_busy);
        end
        if (l_core_state !== '0 || l_core_key !== '0) begin
            errors++;
            $display("FAIL reset_core: got %h/%h want 0/0", l_core_state, l_core_key);
        end
        if (l_res_data !== '0 || l_res_src !== 1'b0 || s_res_data !== '0 || s_res_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_res: got %h/%b want 0/0", l_res_data, l_res_src);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        res_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_fips();
        int k;
        sel = 1'b0;
        res_ready = 1'b1;
        a_key = 128'h000102030405060708090a0b0c0d0e0f;
        a_state = 128'h00112233445566778899aabbccddeeff;
        a_valid = 1'b1;
        #1;
        checks++;
        if (l_a_ready !== 1'b1) begin
            errors++;
            $display("FAIL fips_issue: got a_ready=%b want 1", l_a_ready);
        end
        step();
        a_valid = 1'b0;
        k = 1;
        #1;
        while (l_res_valid !== 1'b1 && k < LAT + 6) begin
            step();
            #1;
            k++;
        end
        checks += 2;
        if (k != LAT + 1) begin
            errors++;
            $display("FAIL fips_latency: got %0d cycles want %0d", k, LAT + 1);
        end
        if (l_res_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || l_res_src !== 1'b0) begin
            errors++;
            $display("FAIL fips_data: got %b/%h want 0/69c4e0d86a7b0430d8cdb78070b4c55a", l_res_src, l_res_data);
        end
        step();
        #1;
        checks++;
        if (l_busy !== 1'b0 || l_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL fips_busy_after_pop: got busy=%b res_valid=%b want 0 0", l_busy, l_res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_contention();
        int n;
        sel = 1'b0;
        pulse_reset();
        res_ready = 1'b1;
        b_key = '0;
        b_state = '0;
        a_key = rand128();
        a_state = rand128();
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({l_a_ready, l_b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_grant %0d: got a=%b b=%b want a=%b", i, l_a_ready, l_b_ready, i % 2 == 0);
            end
            step();
            if (i % 2 == 0) begin
                a_key = rand128();
                a_state = rand128();
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        n = 0;
        for (int i = 0; i < LAT + 30 && n < 10; i++) begin
            #1;
            if (l_res_valid) begin
                checks++;
                if (l_res_src !== 1'(n % 2)) begin
                    errors++;
                    $display("FAIL contention_src %0d: got %b want %0d", n, l_res_src, n % 2);
                end
                if (l_res_src) begin
                    checks++;
                    if (l_res_data !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
                        errors++;
                        $display("FAIL contention_b_data: got %h want 66e94bd4ef8a2c3b884cfa59ca342b2e", l_res_data);
                    end
                end
                n++;
            end
            step();
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL contention_count: got %0d results want 10", n);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int   acc;
        int   p0;
        logic took;
        sel = 1'b1;
        pulse_reset();
        res_ready = 1'b0;
        a_valid = 1'b1;
        a_state = rand128();
        a_key = rand128();
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            took = s_a_ready;
            if (took) acc++;
            step();
            if (took) begin
                a_state = rand128();
                a_key = rand128();
            end
        end
        #1;
        checks += 2;
        if (acc != DS) begin
            errors++;
            $display("FAIL bp_accepts: got %0d want %0d", acc, DS);
        end
        if (s_a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got a_ready=%b want 0", s_a_ready);
        end
        p0 = pops;
        res_ready = 1'b1;
        #1;
        checks++;
        if (s_res_valid !== 1'b1 || s_a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_pop_cycle: got res_valid=%b a_ready=%b want 1 0", s_res_valid, s_a_ready);
        end
        step();
        res_ready = 1'b0;
        #1;
        checks++;
        if (s_a_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_return: got a_ready=%b want 1", s_a_ready);
        end
        step();
        a_state = rand128();
        a_key = rand128();
        #1;
        checks++;
        if (s_a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_restall: got a_ready=%b want 0", s_a_ready);
        end
        drain(LAT + 20);
        checks += 2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d outstanding want 0", exp_q.size());
        end
        if (pops - p0 != DS + 1) begin
            errors++;
            $display("FAIL bp_pop_count: got %0d want %0d", pops - p0, DS + 1);
        end
    endtask

    task automatic test_push_pop_full();
        int p0;
        sel = 1'b1;
        pulse_reset();
        res_ready = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < DS - 1; i++) begin
            a_state = rand128();
            a_key = rand128();
            #1;
            checks++;
            if (s_a_ready !== 1'b1) begin
                errors++;
                $display("FAIL ppf_fill %0d: got a_ready=%b want 1", i, s_a_ready);
            end
            step();
        end
        a_valid = 1'b0;
        repeat (7) step();
        a_valid = 1'b1;
        a_state = rand128();
        a_key = rand128();
        #1;
        checks++;
        if (s_a_ready !== 1'b1) begin
            errors++;
            $display("FAIL ppf_last_issue: got a_ready=%b want 1", s_a_ready);
        end
        step();
        a_valid = 1'b0;
        repeat (LAT - 1) step();
        p0 = pops;
        res_ready = 1'b1;
        #1;
        checks++;
        if (s_res_valid !== 1'b1) begin
            errors++;
            $display("FAIL ppf_head: got res_valid=%b want 1", s_res_valid);
        end
        step();
        res_ready = 1'b0;
        repeat (3) step();
        drain(20);
        checks += 2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ppf_drain: got %0d outstanding want 0", exp_q.size());
        end
        if (pops - p0 != DS) begin
            errors++;
            $display("FAIL ppf_pop_count: got %0d want %0d", pops - p0, DS);
        end
    endtask

    task automatic test_reset_midstream();
        sel = 1'b0;
        res_ready = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_state = rand128();
            a_key = rand128();
            #1;
            checks++;
            if (l_a_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_issue %0d: got a_ready=%b want 1", i, l_a_ready);
            end
            step();
        end
        a_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < LAT + 8; i++) begin
            #1;
            checks++;
            if (l_res_valid !== 1'b0 || l_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale %0d: got res_valid=%b busy=%b want 0 0", i, l_res_valid, l_busy);
            end
            step();
        end
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_state = rand128();
        a_key = rand128();
        b_state = rand128();
        b_key = rand128();
        #1;
        checks++;
        if ({l_a_ready, l_b_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_first_tie: got a=%b b=%b want a=1 b=0", l_a_ready, l_b_ready);
        end
        step();
        a_state = rand128();
        a_key = rand128();
        #1;
        checks++;
        if ({l_a_ready, l_b_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_second_tie: got a=%b b=%b want a=0 b=1", l_a_ready, l_b_ready);
        end
        step();
        drain(LAT + 20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_drain: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_stream();
        sel = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < LAT + 56; k++) begin
            b_valid = (k < 50);
            b_state = rand128();
            b_key = rand128();
            #1;
            checks += 2;
            if (l_b_ready !== (k < 50)) begin
                errors++;
                $display("FAIL stream_ready %0d: got %b want %b", k, l_b_ready, k < 50);
            end
            if (l_res_valid !== (k >= LAT + 1 && k <= LAT + 50)) begin
                errors++;
                $display("FAIL stream_res_valid %0d: got %b want %b", k, l_res_valid, k >= LAT + 1 && k <= LAT + 50);
            end
            step();
        end
        b_valid = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_fips();
        test_contention();
        test_backpressure();
        test_push_pop_full();
        test_reset_midstream();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
